ct_f_spsram_init_wrap: RTL and testbench

Parametrised FPGA single-port SRAM wrapper with a hardware clear sequencer, optional output pipeline register, and a read-valid strobe.
- After reset, or on request, it walks every address and writes INIT_VAL, then opens the macro-style port to its client.
- Replaces fixed-size spsram wrappers in L1/L2 tag and data arrays that need a known array state without a software clear loop.

---
 rtl/ct_f_spsram_init_wrap.sv | 180 ++++++++++++++++++
 tb/tb_ct_f_spsram_init_wrap.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ct_f_spsram_init_wrap.sv
// Single-port SRAM wrapper that clears every entry to INIT_VAL after reset or on request.
// Latency: reads return 1 cycle after issue (OUT_REG=0) or 2 cycles (OUT_REG=1); the clear takes DEPTH cycles.
// Backpressure: none; client accesses presented while init_busy is high are silently dropped.
//
// Ports:
//   forever_cpuclk  clock, all state on the rising edge
//   cpurst_b        asynchronous active-low reset
//   init_req        pulse; starts a full clear when the wrapper is open to the client
//   A/CEN/GWEN/WEN/D  macro-style access port (CEN, GWEN, WEN active-low)
//   Q / rd_vld      read data and its one-cycle "new data" strobe
//   init_busy       clear in progress
//   init_done       sticky; at least one clear has completed since reset
module ct_f_spsram_init_wrap #(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 144,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  rd_vld,
    output logic                  init_busy,
    output logic                  init_done
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;

    // Client access qualification. A request cycle also drops the client
    // access so the clear starts from a clean array view.
    logic                    acc_en;
    logic                    cli_wr;
    logic                    cli_rd;

    assign acc_en = (state == ST_RUN) && !CEN && !init_req;
    assign cli_wr = acc_en && !GWEN;
    assign cli_rd = acc_en &&  GWEN;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state     <= ST_INIT;
            cnt       <= '0;
            init_busy <= 1'b1;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // Counter wraps back to 0 after the last address, so a
                    // later clear naturally starts from address 0 again.
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        state     <= ST_INIT;
                        cnt       <= '0;
                        init_busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    cnt       <= '0;
                    init_busy <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single write port shared by the clear sequencer and the client.
    // wr_bit is active-high per-bit enable.
    // ------------------------------------------------------------------
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_dat;
    logic [DATA_WIDTH-1:0]   wr_bit;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = A;
        wr_dat  = D;
        wr_bit  = ~WEN;
        if (state == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_dat  = INIT_VAL;
            wr_bit  = '1;
        end else if (cli_wr) begin
            wr_en   = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset so it maps onto block RAM with bit write enables.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge forever_cpuclk) begin
        if (wr_en) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (wr_bit[i]) begin
                    mem[wr_addr][i] <= wr_dat[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Synchronous read stage. rd_dat only loads on a real read so it holds
    // its last value through idle cycles and through a clear.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   rd_dat;
    logic                    rd_vld_p1;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_dat    <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= cli_rd;
            if (cli_rd) begin
                rd_dat <= mem[A];
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional output register. In-flight reads are independent of the
    // sequencer state, so a read issued before a clear request still
    // completes with its strobe.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] q_r;
            logic                  vld_r;

            always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    q_r   <= '0;
                    vld_r <= 1'b0;
                end else begin
                    vld_r <= rd_vld_p1;
                    if (rd_vld_p1) begin
                        q_r <= rd_dat;
                    end
                end
            end

            assign Q      = q_r;
            assign rd_vld = vld_r;
        end else begin : g_noreg
            assign Q      = rd_dat;
            assign rd_vld = rd_vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_ct_f_spsram_init_wrap.sv
module tb_ct_f_spsram_init_wrap;

    localparam int          AW   = 4;
    localparam int          DW   = 16;
    localparam logic [15:0] IV   = 16'hA5A5;

    logic          forever_cpuclk;
    logic          cpurst_b;
    logic          init_req;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;

    logic [DW-1:0] q0, q1;
    logic          vld0, vld1, busy0, busy1, done0, done1;

    int checks = 0;
    int errors = 0;

    // OUT_REG=0 and OUT_REG=1 instances see identical stimulus.
    ct_f_spsram_init_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .INIT_VAL(IV)) u_dut0 (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b), .init_req(init_req),
        .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .Q(q0), .rd_vld(vld0), .init_busy(busy0), .init_done(done0)
    );

    ct_f_spsram_init_wrap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .INIT_VAL(IV)) u_dut1 (
        .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b), .init_req(init_req),
        .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D),
        .Q(q1), .rd_vld(vld1), .init_busy(busy1), .init_done(done1)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    typedef struct {
        logic          cen;
        logic          gwen;
        logic          req;
        logic [AW-1:0] a;
        logic [DW-1:0] wen;
        logic [DW-1:0] d;
        logic          v0;
        logic [DW-1:0] eq0;
        logic          v1;
        logic [DW-1:0] eq1;
        logic          busy;
    } vec_t;

    vec_t vq[$];

    function automatic void vec(input logic cen, input logic gwen, input logic req,
                                input logic [AW-1:0] a, input logic [DW-1:0] wen,
                                input logic [DW-1:0] d, input logic v0, input logic [DW-1:0] eq0,
                                input logic v1, input logic [DW-1:0] eq1, input logic busy);
        vec_t t;
        t.cen = cen; t.gwen = gwen; t.req = req; t.a = a; t.wen = wen; t.d = d;
        t.v0 = v0; t.eq0 = eq0; t.v1 = v1; t.eq1 = eq1; t.busy = busy;
        vq.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Step clock edges until both instances report init_done; the clear
    // must take exactly 16 edges after the release/request point.
    task automatic wait_clear(input string tag);
        int e0, e1;
        bit bad;
        e0 = 0; e1 = 0; bad = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge forever_cpuclk); #1;
            if (e0 == 0 && done0) e0 = n;
            if (e1 == 0 && done1) e1 = n;
            if (e0 == 0 && (busy0 !== 1'b1 || vld0 !== 1'b0)) bad = 1;
            if (e1 == 0 && (busy1 !== 1'b1 || vld1 !== 1'b0)) bad = 1;
            if (e0 != 0 && e1 != 0) break;
        end
        CEN = 1'b1; GWEN = 1'b1;
        chk({tag, "_clear_len0"}, e0, 16);
        chk({tag, "_clear_len1"}, e1, 16);
        chk({tag, "_busy_novld_in_clear"}, {31'd0, bad}, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_q0"}, q0, 0);      chk({tag, "_q1"}, q1, 0);
        chk({tag, "_vld0"}, vld0, 0);  chk({tag, "_vld1"}, vld1, 0);
        chk({tag, "_busy0"}, busy0, 1); chk({tag, "_busy1"}, busy1, 1);
        chk({tag, "_done0"}, done0, 0); chk({tag, "_done1"}, done1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cpurst_b = 1'b0; init_req = 1'b0; A = '0; CEN = 1'b1; GWEN = 1'b1;
        WEN = '1; D = '0;

        // ---------------- table ----------------
        // Read every address: all hold the clear value.
        for (int k = 0; k < 16; k++)
            vec(0, 1, 0, 4'(k), 16'hFFFF, 16'h0, 1, IV, (k >= 1), (k >= 1) ? IV : 16'h0000, 0);
        vec(1, 1, 0, 4'd0, 16'hFFFF, 16'h0, 0, IV, 1, IV, 0);
        // Bit-masked writes to address 3.
        vec(0, 0, 0, 4'd3, 16'hFF00, 16'hFFFF, 0, IV,       0, IV,       0);
        vec(0, 1, 0, 4'd3, 16'hFFFF, 16'h0000, 1, 16'hA5FF, 0, IV,       0);
        vec(0, 0, 0, 4'd3, 16'h0FFF, 16'h0000, 0, 16'hA5FF, 1, 16'hA5FF, 0);
        vec(0, 1, 0, 4'd3, 16'hFFFF, 16'h0000, 1, 16'h05FF, 0, 16'hA5FF, 0);
        vec(1, 1, 0, 4'd0, 16'hFFFF, 16'h0000, 0, 16'h05FF, 1, 16'h05FF, 0);
        // Pipelined reads of 1,2,3 then idle hold.
        vec(0, 0, 0, 4'd1, 16'h0000, 16'h0001, 0, 16'h05FF, 0, 16'h05FF, 0);
        vec(0, 0, 0, 4'd2, 16'h0000, 16'h0002, 0, 16'h05FF, 0, 16'h05FF, 0);
        vec(0, 0, 0, 4'd3, 16'h0000, 16'h0003, 0, 16'h05FF, 0, 16'h05FF, 0);
        vec(0, 1, 0, 4'd1, 16'hFFFF, 16'h0000, 1, 16'h0001, 0, 16'h05FF, 0);
        vec(0, 1, 0, 4'd2, 16'hFFFF, 16'h0000, 1, 16'h0002, 1, 16'h0001, 0);
        vec(0, 1, 0, 4'd3, 16'hFFFF, 16'h0000, 1, 16'h0003, 1, 16'h0002, 0);
        vec(1, 1, 0, 4'd0, 16'hFFFF, 16'h0000, 0, 16'h0003, 1, 16'h0003, 0);
        vec(1, 1, 0, 4'd0, 16'hFFFF, 16'h0000, 0, 16'h0003, 0, 16'h0003, 0);
        // Write followed immediately by read of the same address.
        vec(0, 0, 0, 4'd9, 16'h0000, 16'h5A5A, 0, 16'h0003, 0, 16'h0003, 0);
        vec(0, 1, 0, 4'd9, 16'hFFFF, 16'h0000, 1, 16'h5A5A, 0, 16'h0003, 0);
        vec(1, 1, 0, 4'd0, 16'hFFFF, 16'h0000, 0, 16'h5A5A, 1, 16'h5A5A, 0);
        // Re-clear mid-run with a read in flight.
        vec(0, 0, 0, 4'd7, 16'h0000, 16'hBEEF, 0, 16'h5A5A, 0, 16'h5A5A, 0);
        vec(0, 1, 0, 4'd7, 16'hFFFF, 16'h0000, 1, 16'hBEEF, 0, 16'h5A5A, 0);
        vec(0, 0, 1, 4'd7, 16'h0000, 16'h0000, 0, 16'hBEEF, 1, 16'hBEEF, 1);
        // Reads (and a repeated request) during the clear are ignored.
        for (int j = 1; j <= 15; j++)
            vec(0, 1, (j == 8), 4'd7, 16'hFFFF, 16'h0000, 0, 16'hBEEF, 0, 16'hBEEF, 1);
        vec(0, 1, 0, 4'd7, 16'hFFFF, 16'h0000, 0, 16'hBEEF, 0, 16'hBEEF, 0);
        vec(0, 1, 0, 4'd7, 16'hFFFF, 16'h0000, 1, IV,       0, 16'hBEEF, 0);
        vec(1, 1, 0, 4'd0, 16'hFFFF, 16'h0000, 0, IV,       1, IV,       0);

        // ---------------- reset state ----------------
        #12;
        chk_reset_vals("reset");

        // ---------------- first clear, client writes A=5 throughout ----------------
        @(posedge forever_cpuclk); #1;
        cpurst_b = 1'b1;
        CEN = 1'b0; GWEN = 1'b0; A = 4'd5; D = 16'h1234; WEN = 16'h0000;
        wait_clear("init");

        // ---------------- table-driven run ----------------
        foreach (vq[i]) begin
            CEN = vq[i].cen; GWEN = vq[i].gwen; init_req = vq[i].req;
            A = vq[i].a; WEN = vq[i].wen; D = vq[i].d;
            @(posedge forever_cpuclk); #1;
            chk($sformatf("v%0d_q0", i),    q0,    vq[i].eq0);
            chk($sformatf("v%0d_vld0", i),  vld0,  vq[i].v0);
            chk($sformatf("v%0d_q1", i),    q1,    vq[i].eq1);
            chk($sformatf("v%0d_vld1", i),  vld1,  vq[i].v1);
            chk($sformatf("v%0d_busy0", i), busy0, vq[i].busy);
            chk($sformatf("v%0d_busy1", i), busy1, vq[i].busy);
            chk($sformatf("v%0d_done0", i), done0, 1);
        end
        init_req = 1'b0; CEN = 1'b1; GWEN = 1'b1;

        // ---------------- reset mid-read ----------------
        CEN = 1'b0; GWEN = 1'b0; A = 4'd9; D = 16'h1111; WEN = 16'h0000;
        @(posedge forever_cpuclk); #1;
        GWEN = 1'b1; WEN = 16'hFFFF;
        @(posedge forever_cpuclk); #1;
        CEN = 1'b1;
        chk("rd9_vld0", vld0, 1);
        chk("rd9_q0", q0, 16'h1111);
        cpurst_b = 1'b0;
        #1;
        chk_reset_vals("rst_mid_read");
        @(posedge forever_cpuclk); #1;
        chk("rst_inflight_vld1", vld1, 0);
        chk("rst_inflight_q1", q1, 0);

        // ---------------- reset mid-clear ----------------
        cpurst_b = 1'b1;
        repeat (5) begin
            @(posedge forever_cpuclk); #1;
        end
        chk("midclr_busy0", busy0, 1);
        cpurst_b = 1'b0;
        #1;
        chk_reset_vals("rst_mid_clear");
        @(posedge forever_cpuclk); #1;
        cpurst_b = 1'b1;
        wait_clear("reclear");

        // Address 9 was overwritten by the new clear.
        CEN = 1'b0; GWEN = 1'b1; A = 4'd9;
        @(posedge forever_cpuclk); #1;
        CEN = 1'b1;
        chk("post_rst_q0", q0, IV);
        chk("post_rst_vld0", vld0, 1);
        @(posedge forever_cpuclk); #1;
        chk("post_rst_q1", q1, IV);
        chk("post_rst_vld1", vld1, 1);
        chk("post_rst_vld0_idle", vld0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
